// File: rtl/difftest_deferred_pkg.sv
// Shared types, default widths and the saturating-add helper for the
// deferred step batcher.
package difftest_deferred_pkg;

    localparam int unsigned DEF_NUM_CORES       = 1;
    localparam int unsigned DEF_STEP_WIDTH      = 8;
    localparam int unsigned DEF_ACC_WIDTH       = 16;
    localparam int unsigned DEF_BATCH_THRESHOLD = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 1024;
    localparam int unsigned DEF_RESULT_WIDTH    = 8;

    // Widest accumulator the saturating helper supports.
    localparam int unsigned SAT_MAX_W = 32;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] sum;
    } sat_t;

    function automatic sat_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                     input logic [SAT_MAX_W-1:0] b,
                                     input int unsigned          width);
        logic [SAT_MAX_W:0] full;
        logic [SAT_MAX_W:0] lim;
        sat_t               r;
        full = {1'b0, a} + {1'b0, b};
        lim  = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
        if (full > lim) begin
            r.ovf = 1'b1;
            r.sum = lim[SAT_MAX_W-1:0];
        end else begin
            r.ovf = 1'b0;
            r.sum = full[SAT_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/deferred_step_acc.sv
// Single-channel saturating step accumulator. Exposes the post-update sum so
// the caller can snapshot it in the same cycle it clears the register.
module deferred_step_acc
    import difftest_deferred_pkg::*;
#(
    parameter int unsigned STEP_WIDTH = DEF_STEP_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned THRESHOLD  = DEF_BATCH_THRESHOLD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  clear,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  above,
    output logic                  overflow
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    sat_t                 sat;

    // NOTE: every output of a combinational block is assigned on every path
    // (here unconditionally) so no latch can be inferred.
    always_comb begin
        sat      = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(step), ACC_WIDTH);
        sum      = ACC_WIDTH'(sat.sum);
        overflow = ovf_q | sat.ovf;
        above    = SAT_MAX_W'(sum) >= SAT_MAX_W'(THRESHOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= sum;
            ovf_q <= overflow;
        end
    end

endmodule

// File: rtl/deferred_step_batcher.sv
// Batches per-core commit step counts into valid/ready flush records and
// latches the first non-zero deferred result from the host.
module deferred_step_batcher
    import difftest_deferred_pkg::*;
#(
    parameter int unsigned NUM_CORES       = DEF_NUM_CORES,
    parameter int unsigned STEP_WIDTH      = DEF_STEP_WIDTH,
    parameter int unsigned ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int unsigned BATCH_THRESHOLD = DEF_BATCH_THRESHOLD,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int unsigned RESULT_WIDTH    = DEF_RESULT_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0] step,
    input  logic                           force_flush,
    output logic                           flush_valid,
    input  logic                           flush_ready,
    output logic [NUM_CORES*ACC_WIDTH-1:0] flush_steps,
    output logic                           flush_overflow,
    input  logic                           result_valid,
    input  logic [RESULT_WIDTH-1:0]        result_data,
    output logic [RESULT_WIDTH-1:0]        simv_result,
    output logic                           halted
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                         state_q;
    state_t                         state_d;
    logic [NUM_CORES*ACC_WIDTH-1:0] sum_all;
    logic [NUM_CORES-1:0]           above;
    logic [NUM_CORES-1:0]           ovf;
    logic [NUM_CORES-1:0]           nonzero;
    logic [TIMER_W-1:0]             timer_q;
    logic                           any_nonzero;
    logic                           timeout_hit;
    logic                           trigger;
    logic                           result_hit;
    logic                           capture;
    logic                           acc_clear;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        deferred_step_acc #(
            .STEP_WIDTH (STEP_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .THRESHOLD  (BATCH_THRESHOLD)
        ) u_acc (
            .clock    (clock),
            .reset    (reset),
            .step     (step[i*STEP_WIDTH +: STEP_WIDTH]),
            .clear    (acc_clear),
            .sum      (sum_all[i*ACC_WIDTH +: ACC_WIDTH]),
            .above    (above[i]),
            .overflow (ovf[i])
        );
        assign nonzero[i] = |sum_all[i*ACC_WIDTH +: ACC_WIDTH];
    end

    assign any_nonzero = |nonzero;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    // Gating on any_nonzero suppresses empty records from force_flush.
    assign trigger     = any_nonzero && ((|above) || force_flush || timeout_hit);
    assign result_hit  = result_valid && (result_data != '0) && !halted;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: begin
                if (result_hit)   state_d = HALTED;
                else if (trigger) state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_ready) state_d = (halted || result_hit) ? HALTED : ACCUM;
            end
            HALTED:  state_d = HALTED;
            default: state_d = ACCUM;
        endcase
    end

    // Once a result is latched the accumulators are held clear, even while a
    // record is still waiting for its handshake.
    always_comb begin
        flush_valid = 1'b0;
        capture     = 1'b0;
        acc_clear   = 1'b0;
        unique case (state_q)
            ACCUM: begin
                capture   = trigger && !result_hit;
                acc_clear = capture || result_hit;
            end
            FLUSH: begin
                flush_valid = 1'b1;
                acc_clear   = halted || result_hit;
            end
            default: acc_clear = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (capture || state_q != ACCUM) begin
            timer_q <= '0;
        end else if (any_nonzero && TIMEOUT_CYCLES != 0) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_steps    <= '0;
            flush_overflow <= 1'b0;
        end else if (capture) begin
            flush_steps    <= sum_all;
            flush_overflow <= |ovf;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            simv_result <= '0;
            halted      <= 1'b0;
        end else if (result_hit) begin
            simv_result <= result_data;
            halted      <= 1'b1;
        end
    end

endmodule
